// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the convolution row-buffer scheduler.
package conv_sched_pkg;

  localparam int NBANK = 4;
  localparam int KROWS = 3;

  typedef logic [1:0] bank_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT,
    FLUSH
  } state_t;

endpackage

// File: rtl/sched_ring_ptr.sv
// Modulo-NBANK bank pointer; advances by one per pulse, clears synchronously.
module sched_ring_ptr
  import conv_sched_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  clear,
  input  logic  advance,
  output bank_t ptr
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (ptr == bank_t'(NBANK - 1)) ? '0 : ptr + bank_t'(1);
    end
  end

endmodule

// File: rtl/conv_row_scheduler.sv
// Steers incoming rows into a 4-bank ring and launches one 3x3 conv pass per resident window.
// Optional stall statistics counter is built only when SCHED_STATS_EN is defined.
module conv_row_scheduler
  import conv_sched_pkg::*;
#(
  parameter int WIDTH  = 1920,
  parameter int HEIGHT = 1080,
  parameter int AW     = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sof,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [NBANK-1:0] wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic             conv_start,
  output bank_t            base_bank,
  input  logic             conv_busy,
  input  logic             conv_done,
  output logic             frame_done,
  output logic [31:0]      stall_cycles
);

  localparam int RW = $clog2(HEIGHT + 1);

  state_t        state, state_next;
  bank_t         wr_bank, rd_bank;
  logic [2:0]    filled;
  logic [RW-1:0] rows_in, rows_out;
  logic          accept, row_done, retire, launch, last_pass;
  logic          start_pulse, flush_pulse, clear;

  assign clear     = (state == FLUSH);
  assign pix_ready = ((state == RUN) || (state == WAIT)) &&
                     (filled < 3'(NBANK)) && (rows_in < RW'(HEIGHT));
  assign accept    = pix_valid & pix_ready;
  assign row_done  = accept && (wr_addr == AW'(WIDTH - 1));
  assign retire    = (state == WAIT) && conv_done;
  assign launch    = (filled >= 3'(KROWS)) && !conv_busy && (rows_out < RW'(HEIGHT - 2));
  assign last_pass = (rows_out == RW'(HEIGHT - 3));

  always_comb begin
    wr_en = '0;
    if (accept) wr_en[wr_bank] = 1'b1;
  end

  sched_ring_ptr u_wr_ptr (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .advance (row_done),
    .ptr     (wr_bank)
  );

  sched_ring_ptr u_rd_ptr (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .advance (retire),
    .ptr     (rd_bank)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_pulse = 1'b0;
    flush_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (sof) state_next = RUN;
      end
      RUN: begin
        if (launch) begin
          state_next  = WAIT;
          start_pulse = 1'b1;
        end
      end
      WAIT: begin
        if (conv_done) begin
          if (last_pass) begin
            state_next  = FLUSH;
            flush_pulse = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end
      FLUSH: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A row finishing on the same edge as a retire leaves the occupancy unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr    <= '0;
      filled     <= '0;
      rows_in    <= '0;
      rows_out   <= '0;
      base_bank  <= '0;
      conv_start <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      conv_start <= start_pulse;
      frame_done <= flush_pulse;
      if (clear) begin
        wr_addr   <= '0;
        filled    <= '0;
        rows_in   <= '0;
        rows_out  <= '0;
        base_bank <= '0;
      end else begin
        if (start_pulse) base_bank <= rd_bank;
        if (accept)      wr_addr   <= row_done ? '0 : wr_addr + AW'(1);
        if (row_done)    rows_in   <= rows_in + RW'(1);
        if (retire)      rows_out  <= rows_out + RW'(1);
        case ({row_done, retire})
          2'b10:   filled <= filled + 3'd1;
          2'b01:   filled <= filled - 3'd1;
          default: filled <= filled;
        endcase
      end
    end
  end

`ifdef SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      stall_cycles <= '0;
    end else if (pix_valid && !pix_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule
